mux_pipe: RTL and testbench

Parametrised, pipelined N:1 datapath multiplexer for the MIPS core. It generalises the combinational 2:1 32-bit select into a registered stage with NUM_IN inputs, a valid/ready handshake, an echoed select tag and out-of-range select detection. It sits between producer stages, such as forwarding sources or writeback candidates, and a consumer that may stall. An optional skid buffer breaks the ready path.

---
 rtl/mux_pkg.sv | 12 +
 rtl/mux_pipe_reg.sv | 26 ++
 rtl/mux_pipe.sv | 93 +++++++++
 tb/tb_mux_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and select-width helper for mux_pipe
package mux_pkg;

    localparam int MUX_WIDTH_DEF = 32;
    localparam int MUX_MAX_IN    = 16;

    // A 1- or 2-input mux still needs a one-bit select port.
    function automatic int mux_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_pipe_reg.sv
// rtl/mux_pipe_reg.sv - payload register with valid flag, load has priority over clear
module mux_pipe_reg #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_pipe.sv
// rtl/mux_pipe.sv - registered N:1 mux with valid/ready; MUX_PIPE_SKID_EN adds a skid entry
module mux_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH  = MUX_WIDTH_DEF,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = mux_sel_w(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN-1:0][WIDTH-1:0] in_mux,
    input  logic [SEL_W-1:0]             sel_mux,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_mux,
    output logic [SEL_W-1:0]             out_sel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         err_sel
);

    localparam int PW = WIDTH + SEL_W;

    logic [WIDTH-1:0] sel_data;
    logic             sel_oor;
    logic [PW-1:0]    in_pl;
    logic [PW-1:0]    o_q;
    logic [PW-1:0]    o_d;
    logic             o_valid;
    logic             o_load;
    logic             o_clear;
    logic             accept;

    // Out-of-range selects fall through the loop and yield zero data.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel_mux) == k) sel_data = in_mux[k];
        end
    end

    assign sel_oor = int'(sel_mux) >= NUM_IN;
    assign in_pl   = {sel_data, sel_mux};
    assign accept  = in_valid && in_ready;

`ifdef MUX_PIPE_SKID_EN
    logic [PW-1:0] s_q;
    logic          s_valid;
    logic          s_load;

    // in_ready depends only on flops, so out_ready never reaches it combinationally.
    assign in_ready = rst_n && !s_valid;
    assign s_load   = accept && o_valid && !out_ready;
    assign o_load   = (!o_valid || out_ready) && (s_valid || accept);
    assign o_d      = s_valid ? s_q : in_pl;
    assign o_clear  = out_ready;

    mux_pipe_reg #(.WIDTH(PW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (s_load),
        .clear (out_ready),
        .d     (in_pl),
        .q     (s_q),
        .valid (s_valid)
    );
`else
    assign in_ready = rst_n && (!o_valid || out_ready);
    assign o_load   = accept;
    assign o_d      = in_pl;
    assign o_clear  = out_ready;
`endif

    mux_pipe_reg #(.WIDTH(PW)) u_out (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (o_load),
        .clear (o_clear),
        .d     (o_d),
        .q     (o_q),
        .valid (o_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)                 err_sel <= 1'b0;
        else if (accept && sel_oor) err_sel <= 1'b1;
    end

    assign out_mux   = o_q[PW-1:SEL_W];
    assign out_sel   = o_q[SEL_W-1:0];
    assign out_valid = o_valid;

endmodule

// File: tb/tb_mux_pipe.sv
// tb/tb_mux_pipe.sv - directed vector bench for mux_pipe (default build, no skid)
module tb_mux_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0][31:0] in4;
    logic [1:0]       sel4;
    logic             v4, r4, ir4, ov4, err4;
    logic [31:0]      om4;
    logic [1:0]       os4;

    logic [2:0][31:0] in3;
    logic [1:0]       sel3;
    logic             v3, r3, ir3, ov3, err3;
    logic [31:0]      om3;
    logic [1:0]       os3;

    logic [1:0][7:0]  in8;
    logic             sel8;
    logic             v8, r8, ir8, ov8, err8;
    logic [7:0]       om8;
    logic             os8;

    mux_pipe #(.WIDTH(32), .NUM_IN(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_mux(in4), .sel_mux(sel4), .in_valid(v4),
        .in_ready(ir4), .out_mux(om4), .out_sel(os4), .out_valid(ov4),
        .out_ready(r4), .err_sel(err4)
    );

    mux_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_mux(in3), .sel_mux(sel3), .in_valid(v3),
        .in_ready(ir3), .out_mux(om3), .out_sel(os3), .out_valid(ov3),
        .out_ready(r3), .err_sel(err3)
    );

    mux_pipe #(.WIDTH(8), .NUM_IN(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_mux(in8), .sel_mux(sel8), .in_valid(v8),
        .in_ready(ir8), .out_mux(om8), .out_sel(os8), .out_valid(ov8),
        .out_ready(r8), .err_sel(err8)
    );

    typedef struct {
        logic [1:0]  sel;
        logic        v;
        logic        r;
        logic        ir;
        logic [31:0] om;
        logic [1:0]  os;
        logic        ov;
    } vec_t;

    vec_t tbl[12];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_del;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{2'd0, 1'b1, 1'b1, 1'b1, 32'hAABBCCDD, 2'd0, 1'b1};
        tbl[1]  = '{2'd1, 1'b1, 1'b1, 1'b1, 32'h22222222, 2'd1, 1'b1};
        tbl[2]  = '{2'd2, 1'b1, 1'b1, 1'b1, 32'h33333333, 2'd2, 1'b1};
        tbl[3]  = '{2'd3, 1'b1, 1'b1, 1'b1, 32'h44444444, 2'd3, 1'b1};
        tbl[4]  = '{2'd0, 1'b1, 1'b0, 1'b0, 32'h44444444, 2'd3, 1'b1};
        tbl[5]  = '{2'd0, 1'b1, 1'b0, 1'b0, 32'h44444444, 2'd3, 1'b1};
        tbl[6]  = '{2'd0, 1'b1, 1'b1, 1'b1, 32'hAABBCCDD, 2'd0, 1'b1};
        tbl[7]  = '{2'd1, 1'b0, 1'b1, 1'b1, 32'hAABBCCDD, 2'd0, 1'b0};
        tbl[8]  = '{2'd2, 1'b0, 1'b0, 1'b1, 32'hAABBCCDD, 2'd0, 1'b0};
        tbl[9]  = '{2'd2, 1'b1, 1'b0, 1'b1, 32'h33333333, 2'd2, 1'b1};
        tbl[10] = '{2'd3, 1'b0, 1'b0, 1'b0, 32'h33333333, 2'd2, 1'b1};
        tbl[11] = '{2'd3, 1'b1, 1'b1, 1'b1, 32'h44444444, 2'd3, 1'b1};

        rst_n = 1'b0;
        in4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'hAABBCCDD};
        sel4 = 2'd0; v4 = 1'b0; r4 = 1'b1;
        in3 = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        sel3 = 2'd0; v3 = 1'b0; r3 = 1'b1;
        in8 = {8'h5A, 8'hA5};
        sel8 = 1'b1; v8 = 1'b0; r8 = 1'b1;

        edge_sample();
        edge_sample();
        chk("reset out_valid", ov4, 0);
        chk("reset out_mux", om4, 0);
        chk("reset out_sel", os4, 0);
        chk("reset err_sel", err4, 0);
        chk("reset in_ready", ir4, 0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready after reset", ir4, 1);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sel4 = tbl[i].sel; v4 = tbl[i].v; r4 = tbl[i].r;
            #1;
            chk($sformatf("vec%0d in_ready", i), ir4, tbl[i].ir);
            edge_sample();
            chk($sformatf("vec%0d out_mux", i), om4, tbl[i].om);
            chk($sformatf("vec%0d out_sel", i), os4, tbl[i].os);
            chk($sformatf("vec%0d out_valid", i), ov4, tbl[i].ov);
        end

        // Backpressure: a pending beat must wait until the consumer is ready.
        @(negedge clk);
        in4[0] = 32'h11223344; sel4 = 2'd0; v4 = 1'b1; r4 = 1'b1;
        edge_sample();
        chk("bp first", om4, 32'h11223344);
        @(negedge clk);
        in4[0] = 32'h55667788; r4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp stall%0d in_ready", i), ir4, 0);
            edge_sample();
            chk($sformatf("bp stall%0d out_mux", i), om4, 32'h11223344);
            @(negedge clk);
        end
        r4 = 1'b1;
        edge_sample();
        chk("bp release out_mux", om4, 32'h55667788);
        chk("bp release out_valid", ov4, 1);
        @(negedge clk);
        v4 = 1'b0;
        edge_sample();
        chk("bp drained", ov4, 0);

        // Width generalisation on the 8-bit, 2-input instance.
        @(negedge clk);
        v8 = 1'b1;
        edge_sample();
        chk("w8 out_mux", om8, 8'h5A);
        chk("w8 out_sel", os8, 1);
        @(negedge clk);
        v8 = 1'b0;

        // Out-of-range select on the 3-input instance.
        sel3 = 2'b11; v3 = 1'b1;
        edge_sample();
        chk("oor out_mux", om3, 0);
        chk("oor out_sel", os3, 3);
        chk("oor err_sel", err3, 1);
        chk("oor out_valid", ov3, 1);
        @(negedge clk);
        sel3 = 2'd1;
        edge_sample();
        chk("oor next out_mux", om3, 32'hBBBBBBBB);
        chk("oor sticky err_sel", err3, 1);

        // Reset while both instances are stalled with a valid beat.
        @(negedge clk);
        r3 = 1'b0; v4 = 1'b1; r4 = 1'b0; sel4 = 2'd2;
        edge_sample();
        chk("stall out_valid", ov4, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst in_ready", ir4, 0);
        edge_sample();
        chk("rst out_valid", ov4, 0);
        chk("rst out_mux", om4, 0);
        chk("rst dut3 err_sel", err3, 0);
        chk("rst dut3 out_valid", ov3, 0);
        @(negedge clk);
        rst_n = 1'b1; v4 = 1'b0; v3 = 1'b0; r4 = 1'b1; r3 = 1'b1;
        #1;
        chk("post-rst in_ready", ir4, 1);

        // Back-to-back: accept and deliver in the same cycle, no bubbles.
        @(negedge clk);
        in4[0] = 32'hDEADBEEF; sel4 = 2'd0; v4 = 1'b1;
        n_del = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (ov4 && r4) n_del++;
            chk($sformatf("b2b%0d in_ready", i), ir4, 1);
            edge_sample();
            chk($sformatf("b2b%0d out_valid", i), ov4, 1);
            chk($sformatf("b2b%0d out_mux", i), om4, 32'hDEADBEEF);
            @(negedge clk);
        end
        v4 = 1'b0;
        #1;
        if (ov4 && r4) n_del++;
        edge_sample();
        chk("b2b deliveries", n_del, 8);
        chk("b2b drained", ov4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
